// File: rtl/picosoc_sdram_wbuf.sv
// picosoc_sdram_wbuf: posted-write buffer in front of the SDRAM controller port.
// Writes are queued and acknowledged at once; they drain in order. Reads are
// forwarded only once the queue is empty, so read-after-write order holds.
module picosoc_sdram_wbuf #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 21
) (
  input  logic                    clk_logic,
  input  logic                    system_reset_n,
  input  logic [ADDR_WIDTH-1:0]   up_addr,
  input  logic [31:0]             up_data,
  input  logic [3:0]              up_byte_en,
  input  logic                    up_wr,
  input  logic                    up_rd,
  output logic [31:0]             up_q,
  output logic                    up_ready,
  output logic [ADDR_WIDTH-1:0]   dn_addr,
  output logic [31:0]             dn_data,
  output logic [3:0]              dn_byte_en,
  output logic                    dn_wr,
  output logic                    dn_rd,
  input  logic [31:0]             dn_q,
  input  logic                    dn_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  // Entry layout: {addr, data, byte_en}
  localparam int EW = ADDR_WIDTH + 36;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [EW-1:0]           r_mem [DEPTH];
  logic [PW-1:0]           r_head;
  logic [PW-1:0]           r_tail;
  logic [LW-1:0]           r_level;
  logic [31:0]             r_up_q;
  logic                    r_up_ready;
  logic [ADDR_WIDTH-1:0]   r_dn_addr;
  logic [31:0]             r_dn_data;
  logic [3:0]              r_dn_byte_en;
  logic                    r_dn_wr;
  logic                    r_dn_rd;

  logic                    w_full;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_load_wr;
  logic                    w_load_rd;
  logic                    w_rd_done;
  logic [EW-1:0]           w_head_entry;

  // A full queue may still accept when the head is leaving on the same edge.
  // The up_ready term stops a second push while the requester drops up_wr.
  assign w_full       = (r_level == LW'(DEPTH));
  assign w_pop        = (r_state == ST_WRITE) && dn_ready;
  assign w_push       = up_wr && !r_up_ready && (!w_full || w_pop);
  assign w_head_entry = r_mem[r_head];

  assign up_q       = r_up_q;
  assign up_ready   = r_up_ready;
  assign dn_addr    = r_dn_addr;
  assign dn_data    = r_dn_data;
  assign dn_byte_en = r_dn_byte_en;
  assign dn_wr      = r_dn_wr;
  assign dn_rd      = r_dn_rd;
  assign level      = r_level;
  assign idle       = (r_level == '0) && (r_state == ST_IDLE);

  // Downstream FSM state register.
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) r_state <= ST_IDLE;
    else                 r_state <= w_state_next;
  end

  // Next-state logic: a buffered write always takes priority over a read.
  always_comb begin
    w_state_next = r_state;
    w_load_wr    = 1'b0;
    w_load_rd    = 1'b0;
    w_rd_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_level != '0) begin
          w_state_next = ST_WRITE;
          w_load_wr    = 1'b1;
        end else if (up_rd && !r_up_ready) begin
          w_state_next = ST_READ;
          w_load_rd    = 1'b1;
        end
      end
      ST_WRITE: begin
        if (dn_ready) w_state_next = ST_IDLE;
      end
      ST_READ: begin
        if (dn_ready) begin
          w_state_next = ST_IDLE;
          w_rd_done    = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Queue storage: written at the tail, head read feeds the downstream port.
  always_ff @(posedge clk_logic) begin
    if (w_push) r_mem[r_tail] <= {up_addr, up_data, up_byte_en};
  end

  // Queue pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Registered port outputs on both sides.
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_up_q       <= '0;
      r_up_ready   <= 1'b0;
      r_dn_addr    <= '0;
      r_dn_data    <= '0;
      r_dn_byte_en <= '0;
      r_dn_wr      <= 1'b0;
      r_dn_rd      <= 1'b0;
    end else begin
      r_up_ready <= w_push || w_rd_done;
      if (w_load_wr) begin
        r_dn_addr    <= w_head_entry[EW-1 -: ADDR_WIDTH];
        r_dn_data    <= w_head_entry[35:4];
        r_dn_byte_en <= w_head_entry[3:0];
        r_dn_wr      <= 1'b1;
      end
      if (w_load_rd) begin
        r_dn_addr    <= up_addr;
        r_dn_byte_en <= 4'hF;
        r_dn_rd      <= 1'b1;
      end
      if (w_pop) r_dn_wr <= 1'b0;
      if (w_rd_done) begin
        r_dn_rd <= 1'b0;
        r_up_q  <= dn_q;
      end
    end
  end

endmodule

// File: doc/picosoc_sdram_wbuf.md
# picosoc_sdram_wbuf

Posted-write buffer between the PicoSoC SDRAM bridge and its SDRAM controller port. Writes are absorbed into a small FIFO and acknowledged immediately, so the CPU does not stall for the full controller write latency. Writes drain to the controller in order. Reads are forwarded only after the FIFO has fully drained, which preserves read-after-write ordering. Both sides use the sdram port handshake: the requester holds rd/wr until a one-cycle ready pulse.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- ADDR_WIDTH, 21, word address width

Ports:
- clk_logic  in  1  system logic clock; all state on rising edge
- system_reset_n  in  1  asynchronous, active-low reset
- up_addr  in  ADDR_WIDTH  word address from bridge
- up_data  in  32  write data
- up_byte_en  in  4  byte enables for writes
- up_wr  in  1  write request, held until up_ready
- up_rd  in  1  read request, held until up_ready
- up_q  out  32  read data, valid while up_ready=1 for a read
- up_ready  out  1  one-cycle completion pulse, registered
- dn_addr  out  ADDR_WIDTH  address to controller, registered
- dn_data  out  32  write data to controller, registered
- dn_byte_en  out  4  byte enables to controller (4'hF on reads)
- dn_wr  out  1  write request to controller, held until dn_ready
- dn_rd  out  1  read request to controller, held until dn_ready
- dn_q  in  32  controller read data, valid with dn_ready
- dn_ready  in  1  controller completion pulse
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- idle  out  1  FIFO empty and downstream FSM in IDLE

## Operation
- Reset values: up_q=0, up_ready=0, dn_addr=0, dn_data=0, dn_byte_en=0, dn_wr=0, dn_rd=0, level=0, idle=1. All FIFO pointers are 0 and the FSM is in IDLE.
- Accept rule for writes:
  - A write is accepted when up_wr=1, up_ready=0 and level<DEPTH.
  - On acceptance, {addr, data, byte_en} are pushed at the tail.
  - up_ready goes to 1 on the next cycle.
  - The up_ready=0 term blocks a double push while the requester is still dropping its request.
- Full FIFO: up_wr stays pending with up_ready=0 until a pop frees an entry. The push then happens on the same edge as that pop or later.
- Downstream FSM states: IDLE, WRITE, READ.
  - IDLE → WRITE when level>0. dn_addr/dn_data/dn_byte_en load from the head entry and dn_wr is set to 1.
  - IDLE → READ when level=0, up_rd=1 and up_ready=0. dn_addr is loaded from up_addr, dn_byte_en=4'hF and dn_rd is set to 1.
  - A pending write always wins over a read.
  - WRITE: dn_wr holds with stable data. When dn_ready=1 is sampled, the head is popped, dn_wr=0 and the FSM returns to IDLE.
  - READ: dn_rd holds. When dn_ready=1 is sampled, up_q is loaded from dn_q, up_ready pulses on the next cycle, dn_rd=0 and the FSM returns to IDLE.
- Push and pop on the same edge: level is unchanged. Pointers wrap modulo DEPTH.
- A read issued while the FIFO holds entries waits until all entries have drained (level=0, FSM back in IDLE). Only then is it forwarded.
- dn_ready while in IDLE is ignored.
- Reset mid-operation: all buffered writes are discarded, and dn_wr/dn_rd and up_ready drop immediately (asynchronous clear).

## Timing
- Write acknowledge: up_wr sampled at edge k (not full) → up_ready high during cycle k+1 only.
- First downstream write: entry pushed at edge k → FSM samples level>0 at edge k+1 → dn_wr high from cycle k+2 onward.
- Write-to-write gap downstream: at least one IDLE cycle between dn_wr deassertion and the next assertion.
- Read latency with an empty FIFO:
  - up_rd sampled at edge k → dn_rd high from cycle k+1.
  - dn_ready sampled at edge j → up_ready and up_q valid during cycle j+1.
- up_ready is never high for two consecutive cycles.
- dn_wr and dn_rd are never high together.

## Test plan
- Single write: up_wr addr=0x00010, data=0xDEADBEEF, be=4'hF → up_ready pulses 1 cycle later. dn_wr issues the same values. With dn_ready returned after 5 cycles, level goes 1→0 and idle returns to 1.
- Fill and stall: 5 back-to-back writes with DEPTH=4 and dn_ready held low → four acks, level=4, fifth write unacked. Pulse dn_ready once → fifth write is acked on the pop edge +1 and level stays 4.
- Ordering: writes to addresses 1, 2, 3 → dn_addr order 1, 2, 3 with matching data and byte enables (be=4'b0011 preserved).
- Read after writes: 2 writes then up_rd addr=0x5 → dn_rd is asserted only after both writes complete. dn_q=0x12345678 → up_q=0x12345678 with a single up_ready pulse.
- Pointer wrap: 10 write/drain cycles with DEPTH=4 → every dn_addr/dn_data matches its push. Simultaneous push/pop keeps level constant.
- Reset mid-write: assert system_reset_n=0 while dn_wr=1 and level=3 → dn_wr=0 immediately. After release, level=0, idle=1 and no further dn_wr.
